// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM encoding, lane mask width.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam int unsigned ByteMaskW = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_EXEC, ST_RESP} state_e;

  // Stores have no unsigned variants, so only B/H/W are legal for them.
  function automatic logic is_legal_f3(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane logic: store mask/shift, load extract/extend, alignment and funct3 check.
module dmem_lane_align
  import riscv_mem_pkg::*;
(
  input  logic                 we_i,
  input  logic [2:0]           funct3_i,
  input  logic [1:0]           addr_lo_i,
  input  logic [31:0]          wdata_i,
  input  logic [31:0]          rword_i,
  output logic [ByteMaskW-1:0] be_o,
  output logic [31:0]          wdata_lane_o,
  output logic [31:0]          rdata_o,
  output logic                 fmt_err_o
);

  logic [31:0] rshift;
  logic        misalign;

  always_comb begin
    be_o = '0;
    unique case (funct3_i[1:0])
      2'd0:    be_o = 4'b0001 << addr_lo_i;
      2'd1:    be_o = 4'b0011 << addr_lo_i;
      2'd2:    be_o = 4'b1111;
      default: be_o = '0;
    endcase

    misalign = ((funct3_i[1:0] == 2'd1) && addr_lo_i[0]) ||
               ((funct3_i[1:0] == 2'd2) && (addr_lo_i != 2'd0));
    fmt_err_o = misalign || !is_legal_f3(we_i, funct3_i);

    wdata_lane_o = wdata_i << {addr_lo_i, 3'b000};
    rshift       = rword_i >> {addr_lo_i, 3'b000};

    rdata_o = '0;
    unique case (funct3_i)
      F3_B:    rdata_o = {{24{rshift[7]}}, rshift[7:0]};
      F3_H:    rdata_o = {{16{rshift[15]}}, rshift[15:0]};
      F3_W:    rdata_o = rshift;
      F3_BU:   rdata_o = {24'd0, rshift[7:0]};
      F3_HU:   rdata_o = {16'd0, rshift[15:0]};
      default: rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request, WAIT_STATES wait cycles, one EXEC cycle, held response.
// Define DMEM_PARITY_EN to store an even-parity bit per byte and flag load parity errors.
module dmem_responder
  import riscv_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [2:0]  req_funct3_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CntW      = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [31:0] AddrLimit = 32'(4 * DEPTH_WORDS);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              we_q;
  logic [31:0]       addr_q, wdata_q;
  logic [2:0]        f3_q;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [31:0]       mem_q [DEPTH_WORDS];
  logic [AW-1:0]     idx;
  logic              accept, range_err, fmt_err, par_err, acc_err, commit;
  logic [ByteMaskW-1:0] be;
  logic [31:0]       wdata_lane, ld_data;

  assign accept    = (state_q == ST_IDLE) && req_valid_i;
  assign idx       = addr_q[AW+1:2];
  assign range_err = (addr_q >= AddrLimit);

  dmem_lane_align u_align (
    .we_i         (we_q),
    .funct3_i     (f3_q),
    .addr_lo_i    (addr_q[1:0]),
    .wdata_i      (wdata_q),
    .rword_i      (mem_q[idx]),
    .be_o         (be),
    .wdata_lane_o (wdata_lane),
    .rdata_o      (ld_data),
    .fmt_err_o    (fmt_err)
  );

`ifdef DMEM_PARITY_EN
  logic [ByteMaskW-1:0] par_q [DEPTH_WORDS];
  logic [ByteMaskW-1:0] par_bad;

  always_comb begin
    par_bad = '0;
    for (int i = 0; i < ByteMaskW; i++) begin
      par_bad[i] = (^mem_q[idx][8*i +: 8]) ^ par_q[idx][i];
    end
  end
  assign par_err = !we_q && |(be & par_bad);
`else
  assign par_err = 1'b0;
`endif

  assign acc_err = fmt_err || range_err || par_err;
  // rst_ni gate drops a store whose EXEC cycle is cut short by reset.
  assign commit  = (state_q == ST_EXEC) && we_q && !acc_err && rst_ni;

  always_ff @(posedge clk_i) begin
    if (commit) begin
      for (int i = 0; i < ByteMaskW; i++) begin
        if (be[i]) begin
          mem_q[idx][8*i +: 8] <= wdata_lane[8*i +: 8];
`ifdef DMEM_PARITY_EN
          par_q[idx][i] <= ^wdata_lane[8*i +: 8];
`endif
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          cnt_d   = '0;
          state_d = (WAIT_STATES == 0) ? ST_EXEC : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(WAIT_STATES - 1)) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        rsp_err_d   = acc_err;
        rsp_rdata_d = (acc_err || we_q) ? '0 : ld_data;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      f3_q        <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      if (accept) begin
        we_q    <= req_we_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        f3_q    <= req_funct3_i;
      end
    end
  end

  assign req_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder; define DMEM_PARITY_EN to also exercise parity checking.
module tb_dmem_responder;
  import riscv_mem_pkg::*;

  localparam int unsigned Depth = 1024;
  localparam int unsigned Ws    = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH_WORDS (Depth),
    .WAIT_STATES (Ws)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .req_funct3_i (req_funct3),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_err_o    (rsp_err)
  );

  // lat counts clock edges from the accepting edge (inclusive) to the edge raising rsp_valid.
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  lat;
  } rsp_t;

  rsp_t sb_exp[$];
  rsp_t sb_obs[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic release_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] f3, input logic [31:0] erd, input logic eerr,
                       input bit hold);
    rsp_t o;
    int   n;
    sb_exp.push_back('{rdata: erd, err: eerr, lat: 8'(Ws + 2)});
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wdata;
    req_funct3 = f3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    o.lat = 8'd1;
    while (!rsp_valid && o.lat < 8'd60) begin
      @(posedge clk); #1;
      o.lat++;
    end
    o.rdata = rsp_rdata;
    o.err   = rsp_err;
    sb_obs.push_back(o);
    if (!hold) release_rsp();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_err} !== {1'b1, 1'b0, 32'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset: ready=%b valid=%b rdata=%h err=%b, required 1 0 00000000 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    rsp_t e, o;
    issue(1'b1, 32'h10, 32'hDEADBEEF, F3_W, 32'h0, 1'b0, 1'b0);
    issue(1'b0, 32'h10, 32'h0, F3_W, 32'hDEADBEEF, 1'b0, 1'b0);
    while (sb_exp.size() != 0) begin
      e = sb_exp.pop_front();
      o = sb_obs.pop_front();
      n_vec++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL store_load: rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=%0d",
                 o.rdata, o.err, o.lat, e.rdata, e.err, e.lat);
      end
    end
  endtask

  task automatic test_byte_lanes();
    rsp_t e, o;
    issue(1'b1, 32'h11, 32'h80, F3_B, 32'h0, 1'b0, 1'b0);
    issue(1'b0, 32'h11, 32'h0, F3_B, 32'hFFFFFF80, 1'b0, 1'b0);
    issue(1'b0, 32'h11, 32'h0, F3_BU, 32'h00000080, 1'b0, 1'b0);
    issue(1'b0, 32'h10, 32'h0, F3_W, 32'hDEAD80EF, 1'b0, 1'b0);
    issue(1'b0, 32'h12, 32'h0, F3_H, 32'hFFFFDEAD, 1'b0, 1'b0);
    issue(1'b0, 32'h12, 32'h0, F3_HU, 32'h0000DEAD, 1'b0, 1'b0);
    while (sb_exp.size() != 0) begin
      e = sb_exp.pop_front();
      o = sb_obs.pop_front();
      n_vec++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL byte_lanes: rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=%0d",
                 o.rdata, o.err, o.lat, e.rdata, e.err, e.lat);
      end
    end
  endtask

  task automatic test_misaligned();
    rsp_t e, o;
    issue(1'b0, 32'h13, 32'h0, F3_H, 32'h0, 1'b1, 1'b0);
    issue(1'b1, 32'h12, 32'h1, F3_W, 32'h0, 1'b1, 1'b0);
    issue(1'b0, 32'h10, 32'h0, F3_W, 32'hDEAD80EF, 1'b0, 1'b0);
    while (sb_exp.size() != 0) begin
      e = sb_exp.pop_front();
      o = sb_obs.pop_front();
      n_vec++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL misaligned: rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=%0d",
                 o.rdata, o.err, o.lat, e.rdata, e.err, e.lat);
      end
    end
  endtask

  task automatic test_range_funct3();
    rsp_t e, o;
    issue(1'b0, 32'(4 * Depth), 32'h0, F3_W, 32'h0, 1'b1, 1'b0);
    issue(1'b1, 32'(4 * Depth - 4), 32'hA5A55A5A, F3_W, 32'h0, 1'b0, 1'b0);
    issue(1'b0, 32'(4 * Depth - 4), 32'h0, F3_W, 32'hA5A55A5A, 1'b0, 1'b0);
    issue(1'b0, 32'h10, 32'h0, 3'd3, 32'h0, 1'b1, 1'b0);
    issue(1'b1, 32'h10, 32'h0, F3_BU, 32'h0, 1'b1, 1'b0);
    issue(1'b0, 32'h10, 32'h0, F3_W, 32'hDEAD80EF, 1'b0, 1'b0);
    while (sb_exp.size() != 0) begin
      e = sb_exp.pop_front();
      o = sb_obs.pop_front();
      n_vec++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL range_funct3: rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=%0d",
                 o.rdata, o.err, o.lat, e.rdata, e.err, e.lat);
      end
    end
  endtask

  task automatic test_backpressure();
    rsp_t e, o;
    issue(1'b0, 32'h10, 32'h0, F3_W, 32'hDEAD80EF, 1'b0, 1'b1);
    // A competing store held on the request side must not be taken while in RESP.
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_addr   = 32'h10;
    req_wdata  = 32'h0;
    req_funct3 = F3_W;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if ({rsp_valid, rsp_rdata, rsp_err, req_ready} !== {1'b1, 32'hDEAD80EF, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: valid=%b rdata=%h err=%b ready=%b, required 1 dead80ef 0 0",
                 i, rsp_valid, rsp_rdata, rsp_err, req_ready);
      end
    end
    req_valid = 1'b0;
    release_rsp();
    n_vec++;
    if ({req_ready, rsp_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL release_idle: ready=%b valid=%b, required ready=1 valid=0",
               req_ready, rsp_valid);
    end
    issue(1'b0, 32'h10, 32'h0, F3_W, 32'hDEAD80EF, 1'b0, 1'b0);
    while (sb_exp.size() != 0) begin
      e = sb_exp.pop_front();
      o = sb_obs.pop_front();
      n_vec++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL backpressure: rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=%0d",
                 o.rdata, o.err, o.lat, e.rdata, e.err, e.lat);
      end
    end
  endtask

  task automatic test_reset_abort();
    rsp_t e, o;
    issue(1'b1, 32'h20, 32'hCAFEF00D, F3_W, 32'h0, 1'b0, 1'b0);
    issue(1'b0, 32'h20, 32'h0, F3_W, 32'hCAFEF00D, 1'b0, 1'b0);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_addr   = 32'h20;
    req_wdata  = 32'h12345678;
    req_funct3 = F3_W;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    n_vec++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_err} !== {1'b1, 1'b0, 32'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL abort_reset: ready=%b valid=%b rdata=%h err=%b, required 1 0 00000000 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    issue(1'b0, 32'h20, 32'h0, F3_W, 32'hCAFEF00D, 1'b0, 1'b0);
    while (sb_exp.size() != 0) begin
      e = sb_exp.pop_front();
      o = sb_obs.pop_front();
      n_vec++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset_abort: rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=%0d",
                 o.rdata, o.err, o.lat, e.rdata, e.err, e.lat);
      end
    end
  endtask

`ifdef DMEM_PARITY_EN
  task automatic bd_write(input int unsigned widx, input logic [31:0] data);
    dut.mem_q[widx] = data;
    for (int i = 0; i < 4; i++) dut.par_q[widx][i] = ^data[8*i +: 8];
  endtask

  task automatic test_parity();
    rsp_t e, o;
    bd_write(9, 32'h000000FF);
    issue(1'b0, 32'h24, 32'h0, F3_B, 32'hFFFFFFFF, 1'b0, 1'b0);
    dut.par_q[4][0] = ~dut.par_q[4][0];
    issue(1'b0, 32'h10, 32'h0, F3_W, 32'h0, 1'b1, 1'b0);
    issue(1'b0, 32'h12, 32'h0, F3_HU, 32'h0000DEAD, 1'b0, 1'b0);
    while (sb_exp.size() != 0) begin
      e = sb_exp.pop_front();
      o = sb_obs.pop_front();
      n_vec++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL parity: rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=%0d",
                 o.rdata, o.err, o.lat, e.rdata, e.err, e.lat);
      end
    end
  endtask
`endif

  initial begin
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_funct3 = '0;
    rsp_ready  = 1'b0;
    test_reset();
    test_store_load();
    test_byte_lanes();
    test_misaligned();
    test_range_funct3();
    test_backpressure();
    test_reset_abort();
`ifdef DMEM_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
